// File: rtl/mem_bckdoor_rd.sv
// mem_bckdoor_rd
// Burst reader for the memory backdoor channel. A start request issues one
// single-word read per cycle from base_addr upward. Each returned word is
// captured into a small FIFO a fixed RD_LAT cycles after its read strobe. The
// FIFO is then drained through a valid/ready stream.
//
// Ports
//   wb_clk, wb_rst_n  clock (rising edge) and asynchronous active-low reset
//   start             one-cycle burst request, only honoured while idle
//   base_addr         first word address, captured with start
//   burst_len         number of words (0 is ignored)
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle pulse in the cycle the last word is popped
//   mem_read          registered read strobe, one word per high cycle
//   mem_addr          registered read address, valid with mem_read
//   mem_rdata         read data, valid RD_LAT cycles after its strobe
//   rd_data           FIFO head word
//   rd_valid          FIFO not empty
//   rd_ready          consumer accepts rd_data when rd_valid && rd_ready
module mem_bckdoor_rd #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 5
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             mem_read,
    output logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_rdata,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Occupancy can exceed FIFO_DEPTH by the words still in the latency pipe,
    // so one extra bit over the FIFO count.
    localparam int OCC_W = PTR_W + 2;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, next_state;
    logic [AW-1:0]      base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued_cnt;
    logic [LEN_W-1:0]   popped_cnt;
    logic [RD_LAT-1:0]  lat_pipe;
    logic [DW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   in_flight;
    logic [OCC_W-1:0]   occupancy;
    logic               push, pop;
    logic               issue, load;
    logic [AW-1:0]      issue_addr;

    assign push     = lat_pipe[RD_LAT-1];
    assign rd_valid = (fifo_count != '0);
    assign pop      = rd_valid && rd_ready;
    assign rd_data  = fifo_mem[rd_ptr];
    assign busy     = (state != IDLE) && !done;

    // The read currently on the bus is counted as in flight as well. Otherwise
    // a read issued in the same cycle as the credit check could overfill the FIFO.
    always_comb begin
        in_flight = OCC_W'(mem_read);
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + OCC_W'(lat_pipe[i]);
        end
    end

    assign occupancy = fifo_count + in_flight;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The next read is decided here and registered onto mem_read/mem_addr.
    // The first read is therefore launched from IDLE, so that it appears in the
    // cycle right after the start is accepted.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        issue_addr = '0;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (burst_len != '0)) begin
                    load       = 1'b1;
                    issue      = 1'b1;
                    issue_addr = base_addr;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (issued_cnt == len_q) begin
                    next_state = DRAIN;
                end else if (occupancy < DEPTH_OCC) begin
                    issue      = 1'b1;
                    issue_addr = base_q + AW'(issued_cnt);
                end
            end
            DRAIN: begin
                if (pop && (popped_cnt == len_q - LEN_W'(1))) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_cnt <= '0;
            popped_cnt <= '0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
        end else begin
            mem_read <= issue;
            if (issue) begin
                mem_addr <= issue_addr;
            end
            if (load) begin
                base_q     <= base_addr;
                len_q      <= burst_len;
                issued_cnt <= LEN_W'(1);
                popped_cnt <= '0;
            end else begin
                if (issue) begin
                    issued_cnt <= issued_cnt + LEN_W'(1);
                end
                if (pop && (state != IDLE)) begin
                    popped_cnt <= popped_cnt + LEN_W'(1);
                end
            end
        end
    end

    // Delays each read strobe by RD_LAT cycles. The tap at the end marks the
    // cycle in which mem_rdata holds that read's word. Clearing it on reset
    // drops any returns still outstanding.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            lat_pipe <= '0;
        end else begin
            lat_pipe[0] <= mem_read;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_pipe[i] <= lat_pipe[i-1];
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The storage has no reset. Its contents are meaningless while fifo_count is 0.
    always_ff @(posedge wb_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    property no_fifo_overflow;
        @(posedge wb_clk) disable iff (!wb_rst_n) !(push && (fifo_count == DEPTH_OCC));
    endproperty
    assert property (no_fifo_overflow);

endmodule

// File: tb/tb_mem_bckdoor_rd.sv
// tb_mem_bckdoor_rd
// Drives mem_bckdoor_rd against a behavioural backdoor memory. Every accepted
// burst pushes its expected addresses and words (from the memory model) into
// queues. A negedge monitor pops and compares them whenever the DUT strobes a
// read or hands over a word.
module tb_mem_bckdoor_rd;

    localparam int DW         = 32;
    localparam int AW         = 32;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 16;
    localparam int LEN_W      = 5;

    logic             wb_clk = 1'b0;
    logic             wb_rst_n;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic             mem_read;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_ready;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int issued_total = 0;
    int outstanding = 0;
    int ready_mode = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic [DW-1:0] slave_pipe [RD_LAT];

    mem_bckdoor_rd #(
        .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .busy(busy), .done(done), .mem_read(mem_read),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    always #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) cyc++;

    // Backdoor memory contents. The 0x100 window holds 0xA0+offset. Other
    // addresses hold a hash, so misordered or duplicated words are visible.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a >= 32'h100 && a < 32'h200) return 32'hA0 + (a - 32'h100);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Slave with a fixed read latency. Cycles without a read return random
    // junk, so that a capture at the wrong time is caught.
    always @(posedge wb_clk) begin
        slave_pipe[0] <= mem_read ? mem_word(mem_addr) : $urandom;
        for (int i = 1; i < RD_LAT; i++) slave_pipe[i] <= slave_pipe[i-1];
    end
    assign mem_rdata = slave_pipe[RD_LAT-1];

    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge wb_clk);
            #1;
            case (ready_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'b0;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            if (mem_read) begin
                issued_total++;
                outstanding++;
                if (exp_addr_q.size() == 0) check_output("unexpected_mem_read", 1, 0);
                else check_output("mem_addr", mem_addr, exp_addr_q.pop_front());
                check_output("credit_limit", outstanding <= FIFO_DEPTH, 1);
            end
            if (rd_valid && rd_ready) begin
                outstanding--;
                if (exp_data_q.size() == 0) check_output("unexpected_rd_data", 1, 0);
                else check_output("rd_data", rd_data, exp_data_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_output("done_with_words_left", exp_data_q.size(), 0);
                check_output("busy_at_done", busy, 0);
            end
        end
    end

    // Pulses start for one cycle. Only an accepted burst adds expectations.
    task automatic apply_stimulus(input logic [AW-1:0] base, input logic [LEN_W-1:0] len,
                                  input bit accepted, output int start_cyc);
        @(posedge wb_clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        burst_len = len;
        start_cyc = cyc;
        if (accepted) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_addr_q.push_back(base + AW'(i));
                exp_data_q.push_back(mem_word(base + AW'(i)));
            end
        end
        @(posedge wb_clk);
        #1;
        start     = 1'b0;
        base_addr = $urandom;
        burst_len = LEN_W'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge wb_clk);
            n++;
        end
        check_output("done_reached", done_cnt >= target, 1);
        @(posedge wb_clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    initial begin
        int sc;
        int issued_before;
        int done_before;
        int n;
        logic [LEN_W-1:0] rlen;

        wb_rst_n  = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        burst_len = '0;
        ready_mode = 0;
        wait_cycles(3);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_mem_read", mem_read, 0);
        check_output("reset_rd_valid", rd_valid, 0);
        check_output("reset_mem_addr", mem_addr, 0);
        wb_rst_n = 1'b1;
        wait_cycles(2);

        $display("[TB] basic burst");
        apply_stimulus(32'h100, 5'd10, 1'b1, sc);
        check_output("busy_after_start", busy, 1);
        wait_done(1, 200);
        check_output("basic_done_latency", done_cyc - sc, 10 + RD_LAT + 1);
        check_output("basic_busy_after", busy, 0);
        check_output("basic_issued", issued_total, 10);

        $display("[TB] backpressure");
        ready_mode = 1;
        issued_before = issued_total;
        apply_stimulus(32'h140, 5'd20, 1'b1, sc);
        wait_cycles(30);
        check_output("bp_stalled_reads", issued_total - issued_before, FIFO_DEPTH);
        ready_mode = 0;
        wait_done(2, 300);
        check_output("bp_total_reads", issued_total - issued_before, 20);

        $display("[TB] address wrap");
        apply_stimulus(32'hFFFF_FFFE, 5'd3, 1'b1, sc);
        wait_done(3, 200);

        $display("[TB] zero length and overlapping start");
        issued_before = issued_total;
        apply_stimulus(32'h100, 5'd0, 1'b0, sc);
        wait_cycles(5);
        check_output("len0_busy", busy, 0);
        check_output("len0_reads", issued_total - issued_before, 0);
        check_output("len0_done", done_cnt, 3);
        apply_stimulus(32'h180, 5'd8, 1'b1, sc);
        wait_cycles(2);
        apply_stimulus(32'h300, 5'd5, 1'b0, sc);
        wait_done(4, 200);
        wait_cycles(10);
        check_output("overlap_single_done", done_cnt, 4);
        check_output("overlap_reads", issued_total - issued_before, 8);

        $display("[TB] reset mid-burst");
        issued_before = issued_total;
        done_before = done_cnt;
        apply_stimulus(32'h100, 5'd10, 1'b1, sc);
        n = 0;
        while (issued_total - issued_before < 4 && n < 100) begin
            @(negedge wb_clk);
            #1;
            n++;
        end
        check_output("mid_reads_before_reset", issued_total - issued_before >= 4, 1);
        wb_rst_n = 1'b0;
        #1;
        check_output("mid_reset_busy", busy, 0);
        check_output("mid_reset_mem_read", mem_read, 0);
        check_output("mid_reset_rd_valid", rd_valid, 0);
        check_output("mid_reset_mem_addr", mem_addr, 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        outstanding = 0;
        @(posedge wb_clk);
        #1;
        wb_rst_n = 1'b1;
        apply_stimulus(32'h200, 5'd2, 1'b1, sc);
        wait_done(done_before + 1, 200);
        wait_cycles(5);
        check_output("post_reset_done_count", done_cnt, done_before + 1);

        $display("[TB] random backpressure");
        ready_mode = 2;
        for (int b = 0; b < 3; b++) begin
            done_before = done_cnt;
            rlen = (b == 0) ? 5'd31 : LEN_W'($urandom_range(1, 31));
            apply_stimulus($urandom, rlen, 1'b1, sc);
            wait_done(done_before + 1, 3000);
            check_output("random_done_count", done_cnt, done_before + 1);
        end

        ready_mode = 0;
        wait_cycles(5);
        check_output("final_addr_queue", exp_addr_q.size(), 0);
        check_output("final_data_queue", exp_data_q.size(), 0);
        check_output("final_done_total", done_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
